// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory access size encodings and the
// data-memory access controller state encoding.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_BUS  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  // Encoding 2'b11 is treated as a word access.
  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/acknowledge channel between the MEM-stage access unit
// (master) and the data memory (slave).
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for the
// store path, byte/half extraction with sign/zero extension for the load path.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] data_in,
  output logic [3:0]  be,
  output logic [31:0] wr_data,
  output logic [31:0] rd_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // NOTE: every output is given a default before any branch so that no
    // path through the block leaves a value unassigned and infers a latch.
    sel_byte = data_in[7:0];
    sel_half = lane[1] ? data_in[31:16] : data_in[15:0];
    be       = 4'b1111;
    wr_data  = data_in;
    rd_data  = data_in;

    case (lane)
      2'd1:    sel_byte = data_in[15:8];
      2'd2:    sel_byte = data_in[23:16];
      2'd3:    sel_byte = data_in[31:24];
      default: sel_byte = data_in[7:0];
    endcase

    if (!size_is_word(size)) begin
      if (size == SZ_HALF) begin
        // Half accesses only look at addr[1]; addr[0] never shifts the lane.
        be      = 4'b0011 << {lane[1], 1'b0};
        wr_data = {2{data_in[15:0]}};
        rd_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      end else begin
        be      = 4'b0001 << lane;
        wr_data = {4{data_in[7:0]}};
        rd_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: runs a req/ack bus transaction per
// load/store and stalls the pipeline until it completes. Optional alignment
// trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              bus_err,
  output logic              misalign,
  mem_access_unit_if.master bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  ma_state_e     state;
  logic [CW-1:0] tmo_cnt;
  logic          req_go;
  logic          req_misaligned;
  logic          timeout_hit;

  logic [29:0]   lat_word_addr;
  logic [1:0]    lat_lane;
  logic [1:0]    lat_size;
  logic          lat_sign;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;

  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_data;
  logic [31:0]   st_rd_unused;
  logic [3:0]    ld_be_unused;
  logic [31:0]   ld_wr_unused;

  assign req_go      = req_valid & (mem_rd | mem_wr);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  mem_lane_align u_store_align (
    .size     (size),
    .lane     (addr[1:0]),
    .sign_ext (1'b0),
    .data_in  (wdata),
    .be       (st_be),
    .wr_data  (st_wdata),
    .rd_data  (st_rd_unused)
  );

  mem_lane_align u_load_align (
    .size     (lat_size),
    .lane     (lat_lane),
    .sign_ext (lat_sign),
    .data_in  (bus.bus_rdata),
    .be       (ld_be_unused),
    .wr_data  (ld_wr_unused),
    .rd_data  (ld_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign req_misaligned = ((size == SZ_HALF) && addr[0]) ||
                          (size_is_word(size) && (addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if ((state == MA_IDLE) && req_go && req_misaligned) begin
      misalign <= 1'b1;
    end else if (state == MA_DONE) begin
      misalign <= 1'b0;
    end
  end
`else
  assign req_misaligned = 1'b0;
  assign misalign       = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples pre-edge values and the order of statements is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MA_IDLE;
      tmo_cnt       <= '0;
      rdata         <= '0;
      bus_err       <= 1'b0;
      lat_word_addr <= '0;
      lat_lane      <= '0;
      lat_size      <= '0;
      lat_sign      <= 1'b0;
      lat_we        <= 1'b0;
      lat_be        <= '0;
      lat_wdata     <= '0;
    end else begin
      case (state)
        MA_IDLE: begin
          if (req_go) begin
            lat_word_addr <= addr[31:2];
            lat_lane      <= addr[1:0];
            lat_size      <= size;
            lat_sign      <= sign_ext;
            lat_we        <= mem_wr;
            lat_be        <= st_be;
            lat_wdata     <= st_wdata;
            tmo_cnt       <= '0;
            if (req_misaligned) begin
              state <= MA_DONE;
              rdata <= '0;
            end else begin
              state <= MA_BUS;
            end
          end
        end

        MA_BUS: begin
          // An ack in the same cycle as the timeout still completes normally.
          if (bus.bus_ack) begin
            state <= MA_DONE;
            if (!lat_we) begin
              rdata <= ld_data;
            end
          end else if (timeout_hit) begin
            state   <= MA_DONE;
            bus_err <= 1'b1;
            rdata   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end

        MA_DONE: begin
          state   <= MA_IDLE;
          bus_err <= 1'b0;
        end

        default: state <= MA_IDLE;
      endcase
    end
  end

  // The pipeline is frozen from the request cycle until DONE, when it advances.
  assign stall = ((state == MA_IDLE) && req_go) || (state == MA_BUS);

  assign bus.bus_req   = (state == MA_BUS);
  assign bus.bus_we    = lat_we;
  assign bus.bus_addr  = {lat_word_addr, 2'b00};
  assign bus.bus_be    = lat_be;
  assign bus.bus_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed and random loads/stores with a
// bus responder, a completion monitor and a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mips_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_err;
  logic        misalign;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          stalls;
  } exp_t;

  typedef struct {
    int          wait_n;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          ack_inject = 1'b0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_of(input int nb, input logic [31:0] a);
    if (nb == 1) return int'(a[1:0]);
    if (nb == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input int nb, input int idx, input bit sx,
                                             input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] mask;
    v = d >> (8 * idx);
    if (nb == 4) return v;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = v & mask;
    if (sx && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input int nb, input int idx);
    logic [3:0] m;
    m = 4'((1 << nb) - 1);
    return m << idx;
  endfunction

  function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] w);
    if (nb == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (nb == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  // ---------------- bus responder ----------------
  initial begin : responder
    bus_t cur;
    bit   active;
    int   k;
    active = 1'b0;
    k = 0;
    cur = '{wait_n: 0, rdata: '0, we: 1'b0, addr: '0, be: '0, wdata: '0};
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_unexpected_req: bus_req=1 addr=%h with no pending access", bus_if.bus_addr);
            cur = '{wait_n: 0, rdata: '0, we: 1'b0, addr: '0, be: '0, wdata: '0};
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1'b1;
          k = 0;
        end
        check("bus_we", bus_if.bus_we, cur.we);
        check("bus_addr", bus_if.bus_addr, cur.addr);
        check("bus_be", bus_if.bus_be, cur.be);
        if (cur.we) check("bus_wdata", bus_if.bus_wdata, cur.wdata);
        if (ack_inject || (k == cur.wait_n)) begin
          bus_if.bus_ack = 1'b1;
          bus_if.bus_rdata = cur.rdata;
        end else begin
          bus_if.bus_ack = 1'b0;
          bus_if.bus_rdata = $urandom;
        end
        k++;
      end else begin
        active = 1'b0;
        bus_if.bus_ack = ack_inject;
        bus_if.bus_rdata = $urandom;
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : monitor
    exp_t e;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (req_valid && (mem_rd || mem_wr) && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: completion seen with no pending access at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("done_rdata", rdata, e.rdata);
          check("done_bus_err", {31'h0, bus_err}, {31'h0, e.err});
          check("done_misalign", {31'h0, misalign}, {31'h0, e.mis});
          check("stall_cycles", stall_cnt, e.stalls);
        end
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        check("bus_err_outside_done", {31'h0, bus_err}, 32'h0);
        check("misalign_outside_done", {31'h0, misalign}, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] w, input int wt,
                       input logic [31:0] bd);
    exp_t e;
    bus_t b;
    int   nb;
    int   idx;
    bit   mis;
    bit   done;
    nb  = nbytes(sz);
    idx = lane_of(nb, a);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = ((nb == 2) && a[0]) || ((nb == 4) && (a[1:0] != 2'b00));
`endif
    if (mis)
      e = '{rdata: 32'h0, err: 1'b0, mis: 1'b1, stalls: 1};
    else if (wt < TMO)
      e = '{rdata: st ? model_rdata : model_load(nb, idx, sx, bd), err: 1'b0, mis: 1'b0, stalls: wt + 2};
    else
      e = '{rdata: 32'h0, err: 1'b1, mis: 1'b0, stalls: TMO + 1};
    model_rdata = e.rdata;
    if (!mis) begin
      b = '{wait_n: wt, rdata: bd, we: st, addr: {a[31:2], 2'b00},
            be: model_be(nb, idx), wdata: model_wdata(nb, w)};
      bus_q.push_back(b);
    end
    exp_q.push_back(e);

    req_valid = 1'b1;
    mem_rd    = ld;
    mem_wr    = st;
    size      = sz;
    sign_ext  = sx;
    addr      = a;
    wdata     = w;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL txn_complete: stall never dropped within 40 cycles, addr=%h", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit nonmem);
    req_valid = nonmem;
    mem_wr    = 1'b0;
    mem_rd    = nonmem ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clk);
    check("stall_idle", {31'h0, stall}, 32'h0);
    check("bus_req_idle", {31'h0, bus_if.bus_req}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_bus();
    bus_t b;
    b = '{wait_n: 1000, rdata: '0, we: 1'b0, addr: 32'h0000_0300, be: 4'hF, wdata: '0};
    bus_q.push_back(b);
    req_valid = 1'b1;
    mem_rd    = 1'b1;
    mem_wr    = 1'b0;
    size      = SZ_WORD;
    sign_ext  = 1'b0;
    addr      = 32'h0000_0300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bus_req_before_reset", {31'h0, bus_if.bus_req}, 32'h1);
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_rd    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_inject = 1'b1;
    @(negedge clk);
    check("rst_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    ack_inject = 1'b0;
    @(negedge clk);
    check("late_ack_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check("late_ack_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    model_rdata = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [1:0] kind;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check("reset_bus_be", {28'h0, bus_if.bus_be}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_bus_err", {31'h0, bus_err}, 32'h0);
    check("reset_misalign", {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
    issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h5555_5555);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0, 99, 32'h1111_1111);
    issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0502, 32'h0, 3, 32'h9ABC_0000);
    issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0602, 32'h0, 4, 32'h9ABC_0000);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0101, 32'h0, 0, 32'hCAFE_F00D);
    idle_cycle(1'b1);
    reset_mid_bus();
    issue(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0700, 32'h0, 2, 32'h8765_4321);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
      kind = 2'($urandom_range(0, 2));
      issue(kind != 2'd1, kind != 2'd0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom_range(0, 5), $urandom);
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    check("pending_completions", exp_q.size(), 32'h0);
    check("pending_bus_txns", bus_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller for the 5-stage MIPS pipeline. It takes the load/store request from the MEM stage and runs a multi-cycle request/acknowledge transaction on the data bus. While the transaction is pending it holds the MEM→WB pipeline register with `stall`. When the access completes it returns the aligned, extended load data that the MEM/WB register captures as its memory-read value.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUS-state cycles without `bus_ack` before abort; 0 disables timeout.
- `clk  in  1`: single clock; every register updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: MEM stage holds a memory instruction this cycle.
- `mem_rd  in  1`: load.
- `mem_wr  in  1`: store; wins if asserted together with `mem_rd`.
- `size  in  2`: 00 byte, 01 half, 10 word, 11 treated as word.
- `sign_ext  in  1`: sign-extend byte/half loads; otherwise zero-extend.
- `addr  in  32`: byte address (ALU result).
- `wdata  in  32`: store data, taken from the low bits.
- `stall  out  1`: freeze IF..MEM and the MEM→WB register.
- `rdata  out  32`: extended load data, valid in DONE.
- `bus_req  out  1`, `bus_we  out  1`, `bus_addr  out  32` (bits [1:0]=0), `bus_be  out  4`, `bus_wdata  out  32`: bus request channel.
- `bus_ack  in  1`, `bus_rdata  in  32`: bus response.
- `bus_err  out  1`: timeout pulse, valid in DONE.
- `misalign  out  1`: misaligned-access flag, valid in DONE.

## Operation
- States are IDLE, BUS and DONE.
- IDLE → BUS when `req_valid & (mem_rd|mem_wr)`. The request is latched at that edge: `addr`, `size`, `sign_ext`, `we`, lane-shifted `wdata` and `be`.
- BUS → DONE on `bus_ack`. Load data is extracted and extended into the `rdata` register at the same edge.
- BUS → DONE on timeout: `bus_err` is set and `rdata` is 0.
- DONE → IDLE unconditionally. No new request is accepted in DONE; the instruction still present at the inputs is the one that is completing.
- `stall` is combinational: `(IDLE & req_valid & (mem_rd|mem_wr)) | BUS`. It is 0 in DONE, so the pipeline advances at the end of DONE.
- `bus_req` is 1 only in BUS. All `bus_*` outputs are held stable from the latched request for the whole BUS state.
- Lanes are little-endian, with lane = `addr[1:0]`:
  - byte: `be = 4'b0001 << lane`, `bus_wdata = {4{wdata[7:0]}}`.
  - half: `be = 4'b0011 << {addr[1],1'b0}`, `bus_wdata = {2{wdata[15:0]}}`.
  - word: `be = 4'b1111`, `bus_wdata = wdata`.
- Loads select their byte/half from `bus_rdata` using the latched lane, then extend to 32 bits per `sign_ext`.
- Stores leave `rdata` unchanged.

## Timing
- Reset values: state IDLE; `rdata`, `bus_err`, `misalign`, the latched request and the timeout counter are 0. So `bus_req=0`, `bus_be=0`, `stall=0` while `req_valid=0`.
- Reset mid-BUS: `bus_req` drops the cycle after the reset edge and any late `bus_ack` is ignored.
- Zero-wait bus (ack in the first BUS cycle):
  - cycle 0 IDLE, `stall=1`;
  - cycle 1 BUS, `stall=1`, `bus_req=1`;
  - cycle 2 DONE, `stall=0`.
  - MEM/WB captures `rdata` at the end of cycle 2.
- Each extra wait cycle adds exactly one stall cycle.
- The timeout counter clears on entering BUS and increments each BUS cycle without ack. When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE. An ack arriving in the same cycle as the timeout wins.
- `bus_err` and `misalign` are high only during DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - half with `addr[0]=1`, or word with `addr[1:0]!=0`, goes IDLE → DONE directly with no bus transaction;
  - `misalign=1`, `rdata=0`, and `stall` is high for 1 cycle.
- `MEM_ALIGN_CHECK_EN` undefined:
  - the alignment bits are ignored (half uses `addr[1]` only, word uses lane 0);
  - `misalign` is tied to 0.

## Structure
- Shared package `mips_pkg`:
  - size encodings `SZ_BYTE/SZ_HALF/SZ_WORD`;
  - state encoding `MA_IDLE/MA_BUS/MA_DONE`.
- One natural sub-module, `mem_lane_align`, is purely combinational and is instantiated once for the store path and once for the load path:
  - store path: `be` and replicated `wdata` from size/lane;
  - load path: extraction plus extension from `bus_rdata`.

## Test plan
- Word load at 0x100, `bus_ack` in the first BUS cycle, `bus_rdata=0xDEADBEEF` → `bus_addr=0x100`, `be=1111`, 2 stall cycles, `rdata=0xDEADBEEF` in DONE.
- Byte load at 0x103, `sign_ext=1`, `bus_rdata=0x80xxxxxx` → `be=1000`, `rdata=0xFFFFFF80`; same with `sign_ext=0` → `rdata=0x00000080`.
- Half store at 0x202 of `wdata=0x1234ABCD`, ack after 3 wait cycles → `bus_we=1`, `be=1100`, `bus_wdata=0xABCDABCD`, 5 stall cycles, `bus_*` stable throughout.
- `TIMEOUT_CYCLES=4`, no ack → BUS for 4 cycles, then DONE with `bus_err=1`, `rdata=0`, `stall=0`.
- `rst` asserted in the second BUS cycle → the next cycle shows `bus_req=0` and `stall=0` (with `req_valid=0`); a later ack causes no state change.
- With `MEM_ALIGN_CHECK_EN`, word load at 0x101 → `bus_req` never asserts, 1 stall cycle, `misalign=1` in DONE.
